// File: rtl/scratch_pad_arbiter_pkg.sv
// Shared types and helpers for the scratch-pad arbiter and its tag FIFO.
package scratch_pad_arbiter_pkg;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } sp_op_e;

    // Number of bits needed to represent value, never less than one.
    function automatic int unsigned log2(input int unsigned value);
        int unsigned bits;
        bits = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((value >> i) != 0) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// Requester-tag FIFO for in-flight reads; supports push and pop in one cycle, even when full.
module tag_fifo
    import scratch_pad_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 32,
    localparam int unsigned CNT_W = log2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = log2(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/scratch_pad_arbiter.sv
// Round-robin arbiter sharing one scratch-pad port among REQUESTERS clients,
// with in-order read responses routed back through a tag FIFO.
module scratch_pad_arbiter
    import scratch_pad_arbiter_pkg::*;
#(
    parameter int unsigned REQUESTERS      = 4,
    parameter int unsigned WIDTH           = 64,
    parameter int unsigned ADDR_WIDTH      = 12,
    parameter int unsigned MAX_OUTSTANDING = 32,
    localparam int unsigned TAG_WIDTH      = log2(REQUESTERS - 1)
) (
    input  logic                             rst,
    input  logic                             clk,
    input  logic [0:REQUESTERS-1]            req_rd_en,
    input  logic [0:REQUESTERS-1]            req_wr_en,
    input  logic [ADDR_WIDTH*REQUESTERS-1:0] req_addr,
    input  logic [WIDTH*REQUESTERS-1:0]      req_d,
    output logic [0:REQUESTERS-1]            req_full,
    output logic [WIDTH-1:0]                 req_q,
    output logic [0:REQUESTERS-1]            req_valid,
    input  logic [0:REQUESTERS-1]            req_stall,
    output logic                             sp_rd_en,
    output logic                             sp_wr_en,
    output logic [ADDR_WIDTH-1:0]            sp_addr,
    output logic [WIDTH-1:0]                 sp_d,
    input  logic                             sp_full,
    input  logic [WIDTH-1:0]                 sp_q,
    input  logic                             sp_valid,
    output logic                             sp_stall
);

    localparam int unsigned CNT_W = log2(MAX_OUTSTANDING);

    typedef struct packed {
        sp_op_e                op;
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      data;
    } hold_t;

    hold_t                 hold [REQUESTERS];
    logic [REQUESTERS-1:0] hold_vld;
    logic [REQUESTERS-1:0] eligible;
    logic [TAG_WIDTH-1:0]  rr_ptr;
    logic                  gnt_vld;
    logic [TAG_WIDTH-1:0]  gnt_idx;
    logic                  gnt_rd;
    logic                  rd_ok;

    logic                  tag_push;
    logic                  tag_pop;
    logic [TAG_WIDTH-1:0]  tag_head;
    logic                  tag_empty;
    logic                  tag_full;
    logic [CNT_W-1:0]      outstanding;

    // Response routing straight from the scratch-pad to the head tag's owner.
    assign req_q    = sp_q;
    assign sp_stall = ~tag_empty & req_stall[tag_head];
    assign tag_pop  = sp_valid & ~sp_stall & ~tag_empty;

    // A response retiring this cycle frees a slot for a read granted in the same cycle.
    assign rd_ok = ~tag_full | tag_pop;

    always_comb begin
        req_full  = '0;
        req_valid = '0;
        eligible  = '0;
        for (int unsigned i = 0; i < REQUESTERS; i++) begin
            req_full[i]  = hold_vld[i];
            req_valid[i] = sp_valid & ~tag_empty & (tag_head == TAG_WIDTH'(i));
            eligible[i]  = hold_vld[i] & ~sp_full & ((hold[i].op == OP_WRITE) | rd_ok);
        end
    end

    // First eligible entry at or after rr_ptr, wrapping around.
    always_comb begin : rr_select
        int unsigned          idx;
        logic [TAG_WIDTH-1:0] sel;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        sel     = '0;
        for (int unsigned k = 0; k < REQUESTERS; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= REQUESTERS) begin
                idx = idx - REQUESTERS;
            end
            sel = TAG_WIDTH'(idx);
            if (!gnt_vld && eligible[sel]) begin
                gnt_vld = 1'b1;
                gnt_idx = sel;
            end
        end
    end

    assign gnt_rd   = (hold[gnt_idx].op == OP_READ);
    assign tag_push = gnt_vld & gnt_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            hold_vld <= '0;
            sp_rd_en <= 1'b0;
            sp_wr_en <= 1'b0;
            sp_addr  <= '0;
            sp_d     <= '0;
        end else begin
            sp_rd_en <= 1'b0;
            sp_wr_en <= 1'b0;
            if (gnt_vld) begin
                sp_rd_en <= gnt_rd;
                sp_wr_en <= ~gnt_rd;
                sp_addr  <= hold[gnt_idx].addr;
                sp_d     <= hold[gnt_idx].data;
                rr_ptr   <= (gnt_idx == TAG_WIDTH'(REQUESTERS - 1)) ? '0 : gnt_idx + TAG_WIDTH'(1);
            end
            for (int unsigned i = 0; i < REQUESTERS; i++) begin
                if (!hold_vld[i] && (req_rd_en[i] || req_wr_en[i])) begin
                    hold_vld[i] <= 1'b1;
                end else if (gnt_vld && gnt_idx == TAG_WIDTH'(i)) begin
                    hold_vld[i] <= 1'b0;
                end
            end
        end
    end

    // Payload only; a write wins over a simultaneous read.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < REQUESTERS; i++) begin
            if (!hold_vld[i] && (req_rd_en[i] || req_wr_en[i])) begin
                hold[i].op   <= req_wr_en[i] ? OP_WRITE : OP_READ;
                hold[i].addr <= req_addr[(REQUESTERS-1-i)*ADDR_WIDTH +: ADDR_WIDTH];
                hold[i].data <= req_d[(REQUESTERS-1-i)*WIDTH +: WIDTH];
            end
        end
    end

    tag_fifo #(
        .WIDTH (TAG_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tag_push),
        .push_data (gnt_idx),
        .pop       (tag_pop),
        .head      (tag_head),
        .empty     (tag_empty),
        .full      (tag_full),
        .count     (outstanding)
    );

    a_outstanding_bound: assert property (@(posedge clk) disable iff (rst)
        outstanding <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_scratch_pad_arbiter.sv
// Bench for scratch_pad_arbiter: vector table, directed corner sequences and a random run
// checked every cycle against a queue-based reference model.
module tb_scratch_pad_arbiter;

    localparam int R    = 4;
    localparam int W    = 16;
    localparam int AW   = 12;
    localparam int MAXO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [0:R-1]    req_rd_en, req_wr_en, req_stall, req_full, req_valid;
    logic [AW*R-1:0] req_addr;
    logic [W*R-1:0]  req_d;
    logic [W-1:0]    req_q, sp_q, sp_d;
    logic [AW-1:0]   sp_addr;
    logic            sp_rd_en, sp_wr_en, sp_full, sp_valid, sp_stall;

    logic [AW-1:0]   addr [R];
    logic [W-1:0]    data [R];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        req_d    = '0;
        for (int i = 0; i < R; i++) begin
            req_addr[(R-1-i)*AW +: AW] = addr[i];
            req_d[(R-1-i)*W +: W]      = data[i];
        end
    end

    scratch_pad_arbiter #(
        .REQUESTERS      (R),
        .WIDTH           (W),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .rst       (rst),
        .clk       (clk),
        .req_rd_en (req_rd_en),
        .req_wr_en (req_wr_en),
        .req_addr  (req_addr),
        .req_d     (req_d),
        .req_full  (req_full),
        .req_q     (req_q),
        .req_valid (req_valid),
        .req_stall (req_stall),
        .sp_rd_en  (sp_rd_en),
        .sp_wr_en  (sp_wr_en),
        .sp_addr   (sp_addr),
        .sp_d      (sp_d),
        .sp_full   (sp_full),
        .sp_q      (sp_q),
        .sp_valid  (sp_valid),
        .sp_stall  (sp_stall)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: pending slots per requester, a queue of read owners.
    logic          m_vld [R];
    logic          m_wr  [R];
    logic [AW-1:0] m_addr[R];
    logic [W-1:0]  m_data[R];
    int            m_ptr;
    int            tagq[$];
    logic          m_sp_rd, m_sp_wr;
    logic [AW-1:0] m_sp_addr;
    logic [W-1:0]  m_sp_d;

    task automatic model_reset();
        for (int i = 0; i < R; i++) m_vld[i] = 1'b0;
        m_ptr     = 0;
        tagq.delete();
        m_sp_rd   = 1'b0;
        m_sp_wr   = 1'b0;
        m_sp_addr = '0;
        m_sp_d    = '0;
    endtask

    task automatic model_step();
        int   g;
        bit   pop;
        logic old_vld [R];
        if (rst) begin
            model_reset();
            return;
        end
        pop = sp_valid && tagq.size() > 0 && !req_stall[tagq[0]];
        g = -1;
        for (int k = 0; k < R; k++) begin
            int j = (m_ptr + k) % R;
            if (g < 0 && m_vld[j] && !sp_full && (m_wr[j] || tagq.size() < MAXO || pop)) g = j;
        end
        for (int i = 0; i < R; i++) old_vld[i] = m_vld[i];
        m_sp_rd = 1'b0;
        m_sp_wr = 1'b0;
        if (g >= 0) begin
            m_sp_wr   = m_wr[g];
            m_sp_rd   = !m_wr[g];
            m_sp_addr = m_addr[g];
            m_sp_d    = m_data[g];
            m_vld[g]  = 1'b0;
            m_ptr     = (g + 1) % R;
        end
        if (pop) void'(tagq.pop_front());
        if (g >= 0 && m_sp_rd) tagq.push_back(g);
        for (int i = 0; i < R; i++) begin
            if (!old_vld[i] && (req_rd_en[i] || req_wr_en[i])) begin
                m_vld[i]  = 1'b1;
                m_wr[i]   = req_wr_en[i];
                m_addr[i] = addr[i];
                m_data[i] = data[i];
            end
        end
    endtask

    task automatic check_model();
        logic [0:R-1] ef, ev;
        logic         es;
        ef = '0;
        ev = '0;
        es = 1'b0;
        for (int i = 0; i < R; i++) ef[i] = m_vld[i];
        if (tagq.size() > 0) begin
            if (sp_valid) ev[tagq[0]] = 1'b1;
            es = req_stall[tagq[0]];
        end
        chk("model.sp_rd_en", 64'(sp_rd_en), 64'(m_sp_rd));
        chk("model.sp_wr_en", 64'(sp_wr_en), 64'(m_sp_wr));
        chk("model.sp_addr", 64'(sp_addr), 64'(m_sp_addr));
        chk("model.sp_d", 64'(sp_d), 64'(m_sp_d));
        chk("model.req_full", 64'(req_full), 64'(ef));
        chk("model.req_valid", 64'(req_valid), 64'(ev));
        chk("model.sp_stall", 64'(sp_stall), 64'(es));
        chk("model.req_q", 64'(req_q), 64'(sp_q));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
    task automatic sample();
        #4;
        check_model();
    endtask

    task automatic adv();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        rst       = 1'b0;
        req_rd_en = '0;
        req_wr_en = '0;
        req_stall = '0;
        sp_full   = 1'b0;
        sp_valid  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        sample();
        adv();
        rst = 1'b0;
    endtask

    task automatic default_addrs();
        for (int i = 0; i < R; i++) begin
            addr[i] = AW'(12'h100 + i);
            data[i] = W'(16'hA000 + i);
        end
    endtask

    typedef struct {
        logic         r;
        logic [0:R-1] rd, wr, st;
        logic         full, valid;
        logic         e_rd, e_wr;
        logic [0:R-1] e_full, e_valid;
        logic         e_stall;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [0:R-1] rd, input logic [0:R-1] wr,
                                input logic full, input logic valid, input logic [0:R-1] st,
                                input logic e_rd, input logic e_wr, input logic [0:R-1] e_full,
                                input logic [0:R-1] e_valid, input logic e_stall);
        vec_t v;
        v.r = r; v.rd = rd; v.wr = wr; v.full = full; v.valid = valid; v.st = st;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_full = e_full; v.e_valid = e_valid; v.e_stall = e_stall;
        return v;
    endfunction

    vec_t tbl [13];
    int   cnt [R];
    int   exp_g, total, who;
    logic [0:R-1] rv_exp [3];
    logic [W-1:0] rq_exp [3];

    initial begin
        idle();
        rst  = 1'b1;
        sp_q = '0;
        default_addrs();
        model_reset();
        @(posedge clk);
        #1;

        //          rst rd       wr       full val stall    erd ewr efull    evalid   estall
        tbl[0]  = mk(1, 4'b0000, 4'b0100, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
        tbl[1]  = mk(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
        tbl[2]  = mk(0, 4'b0000, 4'b0100, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
        tbl[3]  = mk(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0100, 4'b0000, 0);
        tbl[4]  = mk(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0);
        tbl[5]  = mk(0, 4'b0010, 4'b0010, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
        tbl[6]  = mk(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0010, 4'b0000, 0);
        tbl[7]  = mk(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0);
        tbl[8]  = mk(0, 4'b1000, 4'b0000, 0, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
        tbl[9]  = mk(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b1000, 4'b0000, 0);
        tbl[10] = mk(0, 4'b0000, 4'b0000, 0, 1, 4'b1000, 1, 0, 4'b0000, 4'b1000, 1);
        tbl[11] = mk(0, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0, 0, 4'b0000, 4'b1000, 0);
        tbl[12] = mk(0, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);

        for (int k = 0; k < 13; k++) begin
            rst       = tbl[k].r;
            req_rd_en = tbl[k].rd;
            req_wr_en = tbl[k].wr;
            req_stall = tbl[k].st;
            sp_full   = tbl[k].full;
            sp_valid  = tbl[k].valid;
            sample();
            chk($sformatf("tbl%0d.sp_rd_en", k), 64'(sp_rd_en), 64'(tbl[k].e_rd));
            chk($sformatf("tbl%0d.sp_wr_en", k), 64'(sp_wr_en), 64'(tbl[k].e_wr));
            chk($sformatf("tbl%0d.req_full", k), 64'(req_full), 64'(tbl[k].e_full));
            chk($sformatf("tbl%0d.req_valid", k), 64'(req_valid), 64'(tbl[k].e_valid));
            chk($sformatf("tbl%0d.sp_stall", k), 64'(sp_stall), 64'(tbl[k].e_stall));
            adv();
        end

        // Fairness: every requester keeps a write pending.
        do_reset();
        for (int i = 0; i < R; i++) cnt[i] = 0;
        exp_g = 0;
        total = 0;
        req_wr_en = '1;
        for (int c = 0; c < 44; c++) begin
            sample();
            if (sp_wr_en && total < 40) begin
                chk("fair.order", 64'(sp_addr), 64'(12'h100 + exp_g));
                exp_g = (exp_g + 1) % R;
                who = int'(sp_addr) - 'h100;
                if (who >= 0 && who < R) cnt[who]++;
                total++;
            end
            adv();
        end
        idle();
        chk("fair.total", 64'(total), 64'(40));
        for (int i = 0; i < R; i++) chk($sformatf("fair.share%0d", i), 64'(cnt[i]), 64'(10));

        // Read routing: requesters 2, 0, 3 read 5, 6, 7.
        do_reset();
        addr[2] = 12'd5;
        addr[0] = 12'd6;
        addr[3] = 12'd7;
        req_rd_en = 4'b0010; sample(); adv();
        req_rd_en = 4'b1000; sample(); adv();
        req_rd_en = 4'b0001; sample();
        chk("route.sp_addr0", 64'(sp_addr), 64'(5));
        adv();
        idle(); sample();
        chk("route.sp_addr1", 64'(sp_addr), 64'(6));
        adv();
        sample();
        chk("route.sp_addr2", 64'(sp_addr), 64'(7));
        chk("route.sp_rd_en", 64'(sp_rd_en), 64'(1));
        adv();
        rv_exp[0] = 4'b0010; rv_exp[1] = 4'b1000; rv_exp[2] = 4'b0001;
        rq_exp[0] = 16'hAAAA; rq_exp[1] = 16'hBBBB; rq_exp[2] = 16'hCCCC;
        for (int k = 0; k < 3; k++) begin
            sp_valid = 1'b1;
            sp_q     = rq_exp[k];
            sample();
            chk($sformatf("route.valid%0d", k), 64'(req_valid), 64'(rv_exp[k]));
            chk($sformatf("route.q%0d", k), 64'(req_q), 64'(rq_exp[k]));
            adv();
        end
        idle();
        default_addrs();

        // Outstanding cap: four reads in flight, a fifth waits while a write passes it.
        do_reset();
        req_rd_en = 4'b1111; sample(); adv();
        idle();
        for (int c = 0; c < 4; c++) begin sample(); adv(); end
        req_rd_en = 4'b1000;
        req_wr_en = 4'b0100;
        sample(); adv();
        idle(); sample(); adv();
        sample();
        chk("cap.write_granted", 64'(sp_wr_en), 64'(1));
        chk("cap.write_addr", 64'(sp_addr), 64'(12'h101));
        adv();
        for (int c = 0; c < 2; c++) begin
            sample();
            chk("cap.read_held", 64'(req_full), 64'(4'b1000));
            chk("cap.no_read", 64'(sp_rd_en), 64'(0));
            chk("cap.count_full", 64'(dut.u_tag_fifo.count), 64'(4));
            adv();
        end
        sp_valid = 1'b1;
        sp_q     = 16'h1234;
        sample();
        chk("cap.resp_owner", 64'(req_valid), 64'(4'b1000));
        adv();
        sample();
        chk("cap.read_issued", 64'(sp_rd_en), 64'(1));
        chk("cap.read_addr", 64'(sp_addr), 64'(12'h100));
        chk("cap.pushpop_count", 64'(dut.u_tag_fifo.count), 64'(4));
        chk("cap.slot_free", 64'(req_full), 64'(4'b0000));
        adv();
        for (int c = 0; c < 4; c++) begin sample(); adv(); end
        idle(); sample();
        chk("cap.drained", 64'(dut.u_tag_fifo.count), 64'(0));
        adv();

        // Backpressure: scratch-pad full, then a stalled response owner.
        do_reset();
        req_wr_en = 4'b1000;
        req_rd_en = 4'b0100;
        sample(); adv();
        idle();
        sp_full = 1'b1;
        for (int c = 0; c < 10; c++) begin
            sample();
            chk("bp.no_issue", 64'({sp_rd_en, sp_wr_en}), 64'(0));
            chk("bp.full_held", 64'(req_full), 64'(4'b1100));
            adv();
        end
        sp_full = 1'b0;
        sample(); adv();
        sample(); adv();
        sp_valid  = 1'b1;
        req_stall = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("bp.sp_stall", 64'(sp_stall), 64'(1));
            chk("bp.owner", 64'(req_valid), 64'(4'b0100));
            chk("bp.no_pop", 64'(dut.u_tag_fifo.count), 64'(1));
            adv();
        end
        req_stall = '0;
        sample();
        chk("bp.released", 64'(sp_stall), 64'(0));
        adv();
        idle(); sample();
        chk("bp.popped", 64'(dut.u_tag_fifo.count), 64'(0));
        adv();

        // Reset in the middle of traffic.
        req_rd_en = 4'b1111; sample(); adv();
        idle(); sample(); adv();
        sample(); adv();
        rst       = 1'b1;
        req_rd_en = 4'b1111;
        sp_valid  = 1'b1;
        sample(); adv();
        idle();
        sp_valid  = 1'b1;
        req_stall = 4'b1111;
        sample();
        chk("rst.sp_en", 64'({sp_rd_en, sp_wr_en}), 64'(0));
        chk("rst.sp_addr", 64'(sp_addr), 64'(0));
        chk("rst.sp_d", 64'(sp_d), 64'(0));
        chk("rst.req_full", 64'(req_full), 64'(0));
        chk("rst.stray_valid", 64'(req_valid), 64'(0));
        chk("rst.sp_stall", 64'(sp_stall), 64'(0));
        adv();
        idle();

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom % 200) == 0;
            for (int i = 0; i < R; i++) begin
                req_rd_en[i] = ($urandom % 4) == 0;
                req_wr_en[i] = ($urandom % 6) == 0;
                req_stall[i] = ($urandom % 5) == 0;
                addr[i]      = AW'($urandom);
                data[i]      = W'($urandom);
            end
            sp_full  = ($urandom % 7) == 0;
            sp_valid = ($urandom % 3) == 0;
            sp_q     = W'($urandom);
            sample();
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
